// File: rtl/mips_defs.sv
// Shared MIPS datapath encodings: write-back source selects and load-type codes.
package mips_defs;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_DM   = 2'd1,
    WB_LINK = 2'd2,
    WB_HILO = 2'd3
  } wb_src_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

endpackage

// File: rtl/load_ext.sv
// Sub-word load extraction: picks the byte/half lane of a data-memory word,
// extends it, and flags misaligned accesses. Purely combinational.
module load_ext
  import mips_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] dm,
  input  logic [1:0]        off,
  input  logic [2:0]        ld_type,
  output logic [DATA_W-1:0] ext_data,
  output logic              misalign
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  function automatic logic signed [DATA_W-1:0] sext_byte(input logic signed [7:0] b);
    return DATA_W'(b);
  endfunction

  function automatic logic signed [DATA_W-1:0] sext_half(input logic signed [15:0] h);
    return DATA_W'(h);
  endfunction

  assign byte_sel = dm[{off, 3'b000} +: 8];
  assign half_sel = dm[{off[1], 4'b0000} +: 16];

  // Reserved load types fall into the default arm and behave as LW.
  always_comb begin
    ext_data = dm;
    misalign = 1'b0;
    case (ld_type)
      LD_B:  ext_data = sext_byte(byte_sel);
      LD_BU: ext_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_H: begin
        ext_data = sext_half(half_sel);
        misalign = off[0];
      end
      LD_HU: begin
        ext_data = {{(DATA_W-16){1'b0}}, half_sel};
        misalign = off[0];
      end
      default: misalign = (off != 2'b00);
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered MIPS write-back stage: MEM/WB register with stall/flush, load
// extraction, GRF write controls and a retired-instruction counter.
module wb_stage_pipe
  import mips_defs::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 32,
  parameter int LINK_OFFSET = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_34,
  input  logic [31:0]       instr_34,
  input  logic [31:0]       pc_34,
  input  logic [DATA_W-1:0] alu_out_34,
  input  logic [DATA_W-1:0] dm_rd_34,
  input  logic [DATA_W-1:0] hilo_34,
  input  logic              regwrite_34,
  input  logic [REG_AW-1:0] a3_34,
  input  logic [1:0]        mem2reg_34,
  input  logic [2:0]        ld_type_34,
  output logic              grf_we,
  output logic [REG_AW-1:0] grf_a3,
  output logic [DATA_W-1:0] grf_wd,
  output logic [31:0]       pc_4,
  output logic [31:0]       instr_4,
  output logic              valid_4,
  output logic              misalign_4,
  output logic [CNT_W-1:0]  retired
);

  logic              vld_p0;
  logic [31:0]       instr_p0;
  logic [31:0]       pc_p0;
  logic [DATA_W-1:0] alu_p0;
  logic [DATA_W-1:0] dm_p0;
  logic [DATA_W-1:0] hilo_p0;
  logic              regwrite_p0;
  logic [REG_AW-1:0] a3_p0;
  logic [1:0]        mem2reg_p0;
  logic [2:0]        ld_type_p0;
  logic [CNT_W-1:0]  retired_p0;

  logic [DATA_W-1:0] ld_data;
  logic              ld_misalign;

  // ---- MEM/WB boundary: reset > flush > stall > capture ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_p0      <= 1'b0;
      instr_p0    <= '0;
      pc_p0       <= '0;
      alu_p0      <= '0;
      dm_p0       <= '0;
      hilo_p0     <= '0;
      regwrite_p0 <= 1'b0;
      a3_p0       <= '0;
      mem2reg_p0  <= '0;
      ld_type_p0  <= '0;
    end else if (!stall) begin
      vld_p0      <= valid_34;
      instr_p0    <= instr_34;
      pc_p0       <= pc_34;
      alu_p0      <= alu_out_34;
      dm_p0       <= dm_rd_34;
      hilo_p0     <= hilo_34;
      regwrite_p0 <= regwrite_34;
      a3_p0       <= a3_34;
      mem2reg_p0  <= mem2reg_34;
      ld_type_p0  <= ld_type_34;
    end
  end

  // An instruction retires on the edge that moves it out of WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_p0 <= '0;
    end else if (vld_p0 && !stall && !flush) begin
      retired_p0 <= retired_p0 + CNT_W'(1);
    end
  end

  load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .dm       (dm_p0),
    .off      (alu_p0[1:0]),
    .ld_type  (ld_type_p0),
    .ext_data (ld_data),
    .misalign (ld_misalign)
  );

  // ---- WB outputs: driven from registered state only ----
  always_comb begin
    grf_wd = alu_p0;
    case (mem2reg_p0)
      WB_DM:   grf_wd = ld_data;
      WB_LINK: grf_wd = DATA_W'(pc_p0 + 32'(LINK_OFFSET));
      WB_HILO: grf_wd = hilo_p0;
      default: grf_wd = alu_p0;
    endcase
  end

  assign misalign_4 = vld_p0 && (mem2reg_p0 == WB_DM) && ld_misalign;
  assign grf_we     = vld_p0 && regwrite_p0 && (a3_p0 != '0) && !misalign_4;
  assign grf_a3     = a3_p0;
  assign pc_4       = pc_p0;
  assign instr_4    = instr_p0;
  assign valid_4    = vld_p0;
  assign retired    = retired_p0;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: behavioural WB model compared every cycle, plus
// directed vectors with literal expectations; a CNT_W=4 instance covers wrap.
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_34, regwrite_34;
  logic [31:0] instr_34, pc_34, alu_out_34, dm_rd_34, hilo_34;
  logic [4:0]  a3_34;
  logic [1:0]  mem2reg_34;
  logic [2:0]  ld_type_34;

  logic        grf_we, valid_4, misalign_4;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, pc_4, instr_4, retired;
  logic        s_grf_we, s_valid_4, s_misalign_4;
  logic [4:0]  s_grf_a3;
  logic [31:0] s_grf_wd, s_pc_4, s_instr_4;
  logic [3:0]  s_retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage_pipe dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_34(valid_34),
    .instr_34(instr_34), .pc_34(pc_34), .alu_out_34(alu_out_34), .dm_rd_34(dm_rd_34),
    .hilo_34(hilo_34), .regwrite_34(regwrite_34), .a3_34(a3_34), .mem2reg_34(mem2reg_34),
    .ld_type_34(ld_type_34), .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd),
    .pc_4(pc_4), .instr_4(instr_4), .valid_4(valid_4), .misalign_4(misalign_4),
    .retired(retired)
  );

  wb_stage_pipe #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_34(valid_34),
    .instr_34(instr_34), .pc_34(pc_34), .alu_out_34(alu_out_34), .dm_rd_34(dm_rd_34),
    .hilo_34(hilo_34), .regwrite_34(regwrite_34), .a3_34(a3_34), .mem2reg_34(mem2reg_34),
    .ld_type_34(ld_type_34), .grf_we(s_grf_we), .grf_a3(s_grf_a3), .grf_wd(s_grf_wd),
    .pc_4(s_pc_4), .instr_4(s_instr_4), .valid_4(s_valid_4), .misalign_4(s_misalign_4),
    .retired(s_retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Model of the instruction currently sitting in WB and the retire count.
  typedef struct {
    logic        vld;
    logic [31:0] instr, pc, alu, dm, hilo;
    logic        rw;
    logic [4:0]  a3;
    logic [1:0]  m2r;
    logic [2:0]  ld;
  } wb_slot_t;

  wb_slot_t    m;
  int unsigned m_ret;
  bit          m_init = 1'b0;

  always @(posedge clk) begin
    if (!reset && m.vld && !stall && !flush) m_ret++;
    if (reset) begin
      m = '{default: '0};
      m_ret = 0;
      m_init = 1'b1;
    end else if (flush) begin
      m = '{default: '0};
    end else if (!stall) begin
      m = '{valid_34, instr_34, pc_34, alu_out_34, dm_rd_34, hilo_34,
            regwrite_34, a3_34, mem2reg_34, ld_type_34};
    end
  end

  function automatic logic [31:0] load_val(input wb_slot_t s);
    logic [31:0] b, h;
    b = s.dm >> (8 * s.alu[1:0]);
    h = s.dm >> (16 * s.alu[1]);
    case (s.ld)
      3'd1:    return {{24{b[7]}}, b[7:0]};
      3'd2:    return {24'd0, b[7:0]};
      3'd3:    return {{16{h[15]}}, h[15:0]};
      3'd4:    return {16'd0, h[15:0]};
      default: return s.dm;
    endcase
  endfunction

  function automatic logic exp_mis(input wb_slot_t s);
    logic half;
    half = (s.ld == 3'd3) || (s.ld == 3'd4);
    if (!s.vld || s.m2r != 2'd1) return 1'b0;
    if (s.ld == 3'd1 || s.ld == 3'd2) return 1'b0;
    return half ? s.alu[0] : (s.alu[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] exp_wd(input wb_slot_t s);
    case (s.m2r)
      2'd0:    return s.alu;
      2'd1:    return load_val(s);
      2'd2:    return s.pc + 32'd8;
      default: return s.hilo;
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_valid_4", {31'd0, valid_4}, {31'd0, m.vld});
      chk("m_misalign_4", {31'd0, misalign_4}, {31'd0, exp_mis(m)});
      chk("m_grf_we", {31'd0, grf_we},
          {31'd0, m.vld && m.rw && (m.a3 != 5'd0) && !exp_mis(m)});
      chk("m_grf_a3", {27'd0, grf_a3}, {27'd0, m.a3});
      chk("m_grf_wd", grf_wd, exp_wd(m));
      chk("m_pc_4", pc_4, m.pc);
      chk("m_instr_4", instr_4, m.instr);
      chk("m_retired", retired, m_ret);
      chk("m_small_retired", {28'd0, s_retired}, {28'd0, m_ret[3:0]});
      chk("m_small_grf_wd", s_grf_wd, exp_wd(m));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dm,
                       input logic rw, input logic [4:0] a3, input logic [1:0] m2r,
                       input logic [2:0] ld);
    valid_34 = 1'b1; instr_34 = pc ^ 32'hA5A5_0000; pc_34 = pc; alu_out_34 = alu;
    dm_rd_34 = dm; hilo_34 = 32'h0BAD_F00D; regwrite_34 = rw; a3_34 = a3;
    mem2reg_34 = m2r; ld_type_34 = ld;
  endtask

  task automatic idle();
    valid_34 = 1'b0; instr_34 = '0; pc_34 = '0; alu_out_34 = '0; dm_rd_34 = '0;
    hilo_34 = '0; regwrite_34 = 1'b0; a3_34 = '0; mem2reg_34 = '0; ld_type_34 = '0;
  endtask

  localparam logic [31:0] DMW = 32'h80FF_7F01;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    tick(); tick();
    chk("rst_valid_4", {31'd0, valid_4}, 32'd0);
    chk("rst_grf_we", {31'd0, grf_we}, 32'd0);
    chk("rst_grf_wd", grf_wd, 32'd0);
    chk("rst_retired", retired, 32'd0);

    reset = 1'b0;
    issue(32'h0000_3000, 32'h1234_5678, 32'd0, 1'b1, 5'd8, 2'd0, 3'd0);
    tick();
    chk("alu_we", {31'd0, grf_we}, 32'd1);
    chk("alu_a3", {27'd0, grf_a3}, 32'd8);
    chk("alu_wd", grf_wd, 32'h1234_5678);
    chk("alu_ret0", retired, 32'd0);
    idle(); tick();
    chk("alu_ret1", retired, 32'd1);

    issue(32'h3004, 32'h0000_2002, DMW, 1'b1, 5'd5, 2'd1, 3'd1); tick();
    chk("lb_off2", grf_wd, 32'hFFFF_FFFF);
    issue(32'h3008, 32'h0000_0003, DMW, 1'b1, 5'd5, 2'd1, 3'd2); tick();
    chk("lbu_off3", grf_wd, 32'h0000_0080);
    issue(32'h300C, 32'h0000_0000, DMW, 1'b1, 5'd5, 2'd1, 3'd3); tick();
    chk("lh_off0", grf_wd, 32'h0000_7F01);
    issue(32'h3010, 32'h0000_0002, DMW, 1'b1, 5'd5, 2'd1, 3'd4); tick();
    chk("lhu_off2", grf_wd, 32'h0000_80FF);
    issue(32'h3014, 32'h0000_0000, DMW, 1'b1, 5'd5, 2'd1, 3'd0); tick();
    chk("lw_off0", grf_wd, 32'h80FF_7F01);
    chk("lw_we", {31'd0, grf_we}, 32'd1);

    issue(32'h3018, 32'h0000_1001, DMW, 1'b1, 5'd6, 2'd1, 3'd3); tick();
    chk("mis_flag", {31'd0, misalign_4}, 32'd1);
    chk("mis_we", {31'd0, grf_we}, 32'd0);
    chk("mis_ret_before", retired, 32'd6);
    idle(); tick();
    chk("mis_ret_after", retired, 32'd7);

    issue(32'h0000_3000, 32'd0, 32'd0, 1'b1, 5'd31, 2'd2, 3'd0); tick();
    chk("link_wd", grf_wd, 32'h0000_3008);
    chk("link_we", {31'd0, grf_we}, 32'd1);
    issue(32'h0000_3000, 32'd0, 32'd0, 1'b1, 5'd0, 2'd2, 3'd0); tick();
    chk("zero_we", {31'd0, grf_we}, 32'd0);
    chk("zero_wd", grf_wd, 32'h0000_3008);

    issue(32'h4000, 32'h0000_CAFE, 32'd0, 1'b1, 5'd9, 2'd0, 3'd0); tick();
    chk("stl_ret_in", retired, 32'd9);
    issue(32'h4004, 32'h0000_1111, 32'd0, 1'b1, 5'd10, 2'd0, 3'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_wd_hold", grf_wd, 32'h0000_CAFE);
      chk("stl_a3_hold", {27'd0, grf_a3}, 32'd9);
      chk("stl_ret_hold", retired, 32'd9);
    end
    stall = 1'b0; idle(); tick();
    chk("stl_ret_once", retired, 32'd10);
    chk("stl_valid_after", {31'd0, valid_4}, 32'd0);

    issue(32'h5000, 32'h0000_BEEF, 32'd0, 1'b1, 5'd10, 2'd0, 3'd0); tick();
    stall = 1'b1; flush = 1'b1; idle(); tick();
    chk("sf_valid", {31'd0, valid_4}, 32'd0);
    chk("sf_we", {31'd0, grf_we}, 32'd0);
    chk("sf_ret", retired, 32'd10);
    stall = 1'b0; flush = 1'b0; tick();
    chk("sf_ret_after", retired, 32'd10);

    for (int i = 0; i < 6; i++) begin
      issue(32'h6000 + 32'(4 * i), 32'(i), 32'd0, 1'b1, 5'd3, 2'd3, 3'd0);
      tick();
    end
    chk("hilo_wd", grf_wd, 32'h0BAD_F00D);
    idle(); tick();
    chk("wrap_big", retired, 32'd16);
    chk("wrap_small", {28'd0, s_retired}, 32'd0);

    issue(32'h7000, 32'h0000_0042, 32'd0, 1'b1, 5'd4, 2'd0, 3'd0); tick();
    stall = 1'b1; reset = 1'b1; tick();
    chk("rst_stall_valid", {31'd0, valid_4}, 32'd0);
    chk("rst_stall_wd", grf_wd, 32'd0);
    chk("rst_stall_ret", retired, 32'd0);
    stall = 1'b0; reset = 1'b0; idle(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Parametrised write-back stage with its own MEM/WB pipeline register, stall/flush control, sub-word load extraction and a retired-instruction counter. It sits between the MEM stage and the GRF write port and drives the GRF write controls plus the forwarding source for the hazard unit. It replaces the purely combinational write-back mux with a registered stage that supports LB/LBU/LH/LHU, HI/LO and link write-back, and bubble tracking.

Parameters:
DATA_W, 32, datapath width; only 32 is legal because byte lanes are fixed at 4.
REG_AW, 5, GRF address width.
CNT_W, 32, width of the retired-instruction counter.
LINK_OFFSET, 8, added to the captured PC for link write-back (mem2reg=2).

Ports:
clk  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  hold the WB register contents this cycle.
flush  in  1  load a bubble into the WB register this cycle.
valid_34  in  1  MEM-stage slot holds a real instruction.
instr_34  in  32  instruction word.
pc_34  in  32  instruction PC.
alu_out_34  in  DATA_W  ALU result or memory address.
dm_rd_34  in  DATA_W  raw word read from the data memory.
hilo_34  in  DATA_W  HI/LO read value.
regwrite_34  in  1  instruction writes the GRF.
a3_34  in  REG_AW  destination register, already resolved from RegDst.
mem2reg_34  in  2  WD source: 0 ALU, 1 DM, 2 PC+LINK_OFFSET, 3 HI/LO.
ld_type_34  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 reserved and treated as LW.
grf_we  out  1  GRF write enable.
grf_a3  out  REG_AW  GRF write address.
grf_wd  out  DATA_W  GRF write data.
pc_4  out  32  PC of the WB instruction, for debug and trace.
instr_4  out  32  instruction word in WB.
valid_4  out  1  WB slot holds a real instruction.
misalign_4  out  1  misaligned load is present in WB.
retired  out  CNT_W  count of retired instructions.

Behaviour:
- WB register priority at each rising clk: reset > flush > stall > capture.
- reset: every register clears to 0, including valid_4 and retired. All outputs therefore read 0 in the cycle after reset.
- flush: valid_r is cleared and all payload registers clear to 0. Flush wins over a simultaneous stall.
- stall (without flush): all registers hold their values.
- capture (neither flush nor stall): all *_34 inputs are registered. There is 1-cycle latency from MEM inputs to WB outputs.
- Every output is combinational from the registered values only. No *_34 input has a combinational path to any output.
- Byte offset off = alu_r[1:0].
- LB/LBU select byte dm_r[8*off+7 : 8*off]; LB sign-extends, LBU zero-extends.
- LH/LHU select half dm_r[16*off[1]+15 : 16*off[1]]; LH sign-extends, LHU zero-extends.
- LW passes dm_r unchanged, whatever the offset.
- misalign_4 = valid_r & (mem2reg_r==1) & ((LH/LHU & off[0]) | (LW & off!=0)).
- grf_wd selection by mem2reg_r:
  - 0: alu_r.
  - 1: the extracted load value.
  - 2: pc_r + LINK_OFFSET, modulo 2^32.
  - 3: hilo_r.
- grf_we = valid_r & regwrite_r & (a3_r != 0) & ~misalign_4. A write to $0 is never asserted.
- grf_a3 = a3_r, and grf_wd is driven even when grf_we=0. Consumers must qualify on grf_we, including the hazard unit when forwarding.
- retired increments by 1 on a rising edge where valid_r=1, stall=0, flush=0 and reset=0.
  - A stalled instruction is counted only once, when it leaves WB.
  - A flushed WB instruction is not counted.
  - A misaligned load is counted.
  - The counter wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-stall or mid-flush takes effect at the next edge exactly as above.

Decomposition:
- Shared package/include mips_defs:
  - mem2reg codes: WB_ALU, WB_DM, WB_LINK, WB_HILO.
  - load-type codes: LD_W, LD_B, LD_BU, LD_H, LD_HU.
- One sub-module, load_ext: purely combinational (dm word, offset, ld_type) -> extended data plus misalign flag. It is reused later by the MEM stage for store-lane checks.

Test Plan:
- Reset then capture: reset=1 for 2 cycles, then valid_34=1, regwrite=1, a3=8, mem2reg=0, alu=0x12345678 -> one cycle later grf_we=1, grf_a3=8, grf_wd=0x12345678; retired increments to 1 on the following edge.
- Loads: dm_rd=0x80FF7F01, mem2reg=1.
  - LB off=2 -> 0xFFFFFFFF.
  - LBU off=3 -> 0x00000080.
  - LH off=0 -> 0x00007F01.
  - LHU off=2 -> 0x000080FF.
  - LW off=0 -> 0x80FF7F01.
- Misalign: LH with alu=0x1001 -> misalign_4=1, grf_we=0, retired still increments.
- Link and $0: mem2reg=2, pc=0x00003000, a3=31 -> grf_wd=0x00003008, grf_we=1. Same instruction with a3=0 -> grf_we=0.
- Stall/flush:
  - stall=1 for 3 cycles with an instruction in WB -> outputs constant throughout, and retired increments exactly once after stall drops.
  - stall=1 and flush=1 on the same edge -> valid_4=0, grf_we=0, no increment.
- Counter wrap: force retired to all-ones via a CNT_W=4 instance, retire one instruction -> retired=0.
